// File: rtl/svga_pixel_fifo.sv
// ---------------------------------------------------------------------------
// svga_pixel_fifo
//
// Pixel buffer between an upstream pixel source and the 800x600 SVGA output
// stage. The producer pushes RGB444 words at the full clk rate with a
// valid/ready handshake. The consumer side pops one word per pixel strobe
// (pix_ce) while pix_active is high, and drives registered red/green/blue.
// When the buffer is empty, the outputs show BLANK_RGB and a sticky underflow
// flag is set. A frame_sync pulse flushes the buffer.
//
// Storage is an inferred RAM with a registered read. The RAM output register
// doubles as the head (prefetch) register. This hides the read latency: a
// word written in cycle N can be popped in cycle N+2.
//
// Optional feature: define FIFO_WATERMARK_EN to add the level_min output. It
// reports the lowest level seen at read events since the last frame_sync or
// reset.
//
// Ports:
//   clk        in   system clock
//   resetn     in   synchronous active-low reset
//   wr_valid   in   producer has a pixel
//   wr_data    in   pixel {R[3:0],G[3:0],B[3:0]}
//   wr_ready   out  FIFO accepts wr_data this cycle
//   pix_ce     in   one-cycle pixel strobe
//   pix_active in   visible-area flag, qualified by pix_ce
//   frame_sync in   one-cycle flush pulse
//   red/green/blue out  registered pixel colour
//   level      out  occupancy (RAM entries plus head register)
//   underflow  out  sticky: active pixel requested while empty
//   level_min  out  (FIFO_WATERMARK_EN only) minimum level at read events
// ---------------------------------------------------------------------------
module svga_pixel_fifo #(
    parameter int          DEPTH_LOG2 = 9,
    parameter logic [11:0] BLANK_RGB  = 12'h000
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_valid,
    input  logic [11:0]           wr_data,
    output logic                  wr_ready,
    input  logic                  pix_ce,
    input  logic                  pix_active,
    input  logic                  frame_sync,
    output logic [3:0]            red,
    output logic [3:0]            green,
    output logic [3:0]            blue,
    output logic [DEPTH_LOG2:0]   level,
`ifdef FIFO_WATERMARK_EN
    output logic [DEPTH_LOG2:0]   level_min,
`endif
    output logic                  underflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);

    logic [11:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   level_reg;
    logic [DEPTH_LOG2:0]   level_next;
    logic                  head_valid_reg;
    logic                  head_valid_next;
    logic [11:0]           head_reg;
    logic [11:0]           rgb_reg;
    logic                  underflow_reg;

    logic push;
    logic read_event;
    logic pop;
    logic mem_nonempty;
    logic refill;

    assign wr_ready   = (level_reg != FULL_LEVEL) && !frame_sync && resetn;
    assign push       = wr_valid && wr_ready;
    assign read_event = pix_ce && pix_active;
    // Only the head register can be popped. A word that is still in the RAM
    // is not yet visible, so a read event in that case counts as underflow.
    assign pop        = read_event && head_valid_reg;
    // level counts the head register too, so the RAM holds
    // level - head_valid entries.
    assign mem_nonempty = level_reg > {{DEPTH_LOG2{1'b0}}, head_valid_reg};
    assign refill       = mem_nonempty && (!head_valid_reg || pop);

    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
        head_valid_next = head_valid_reg;
        if (refill) begin
            head_valid_next = 1'b1;
        end else if (pop) begin
            head_valid_next = 1'b0;
        end
    end

    // RAM write port; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Registered RAM read, which is also the head register. head_valid_reg
    // qualifies it, so it needs no reset.
    always_ff @(posedge clk) begin
        if (refill) begin
            head_reg <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            level_reg      <= '0;
            head_valid_reg <= 1'b0;
            underflow_reg  <= 1'b0;
        end else if (frame_sync) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            level_reg      <= '0;
            head_valid_reg <= 1'b0;
            underflow_reg  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (refill) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            level_reg      <= level_next;
            head_valid_reg <= head_valid_next;
            if (read_event && !head_valid_reg) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    // The output register is not affected by frame_sync. A read event in the
    // same cycle as frame_sync still shows the pre-flush head.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rgb_reg <= BLANK_RGB;
        end else if (pix_ce) begin
            rgb_reg <= pop ? head_reg : BLANK_RGB;
        end
    end

`ifdef FIFO_WATERMARK_EN
    logic [DEPTH_LOG2:0] level_min_reg;

    always_ff @(posedge clk) begin
        if (!resetn || frame_sync) begin
            level_min_reg <= FULL_LEVEL;
        end else if (read_event && (level_reg < level_min_reg)) begin
            level_min_reg <= level_reg;
        end
    end

    assign level_min = level_min_reg;
`endif

    assign red       = rgb_reg[11:8];
    assign green     = rgb_reg[7:4];
    assign blue      = rgb_reg[3:0];
    assign level     = level_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_svga_pixel_fifo.sv
// ---------------------------------------------------------------------------
// tb_svga_pixel_fifo
//
// Directed testbench for svga_pixel_fifo with the default parameters
// (depth 512, black blanking colour). Every expected value below is a
// hand-computed constant or a simple loop count. Inputs are driven 1 ns after
// a rising edge, and outputs are sampled at the same point after the next
// edge.
// ---------------------------------------------------------------------------
module tb_svga_pixel_fifo;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wr_valid;
    logic [11:0] wr_data;
    logic        wr_ready;
    logic        pix_ce;
    logic        pix_active;
    logic        frame_sync;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic [9:0]  level;
    logic        underflow;
`ifdef FIFO_WATERMARK_EN
    logic [9:0]  level_min;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    svga_pixel_fifo dut (
        .clk        (clk),
        .resetn     (resetn),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .pix_ce     (pix_ce),
        .pix_active (pix_active),
        .frame_sync (frame_sync),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .level      (level),
`ifdef FIFO_WATERMARK_EN
        .level_min  (level_min),
`endif
        .underflow  (underflow)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [11:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic read_px(input logic active);
        pix_ce     = 1'b1;
        pix_active = active;
        tick();
        pix_ce     = 1'b0;
        pix_active = 1'b0;
    endtask

    task automatic sync_pulse();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; wr_valid = 1'b0; wr_data = '0;
        pix_ce = 1'b0; pix_active = 1'b0; frame_sync = 1'b0;
        repeat (3) tick();
        check_val("rst_level", 32'(level), 32'd0);
        check_val("rst_underflow", 32'(underflow), 32'd0);
        check_val("rst_rgb", {20'd0, red, green, blue}, 32'h000);
        check_val("rst_wr_ready", 32'(wr_ready), 32'd0);
        resetn = 1'b1;
        tick();

        // Ten pushes with pix_ce idle.
        for (int i = 0; i < 10; i++) push_word(12'h123 + 12'(i));
        check_val("p10_level", 32'(level), 32'd10);
        check_val("p10_wr_ready", 32'(wr_ready), 32'd1);
        check_val("p10_rgb", {20'd0, red, green, blue}, 32'h000);
        check_val("p10_underflow", 32'(underflow), 32'd0);

        // Fill to 512 entries, then offer one more word.
        for (int i = 10; i < 512; i++) push_word(12'(i));
        check_val("full_level", 32'(level), 32'd512);
        check_val("full_wr_ready", 32'(wr_ready), 32'd0);
        push_word(12'hEEE);
        check_val("full_513th_level", 32'(level), 32'd512);
        sync_pulse();
        check_val("flush_full_level", 32'(level), 32'd0);

        // Three words read back by strobes 4 clk apart.
        push_word(12'hF00);
        push_word(12'h0F0);
        push_word(12'h00F);
        repeat (2) tick();
        read_px(1'b1);
        check_val("rd_f00", {20'd0, red, green, blue}, 32'hF00);
        repeat (3) tick();
        read_px(1'b1);
        check_val("rd_0f0", {20'd0, red, green, blue}, 32'h0F0);
        repeat (3) tick();
        read_px(1'b1);
        check_val("rd_00f", {20'd0, red, green, blue}, 32'h00F);
        check_val("rd_level", 32'(level), 32'd0);
        check_val("rd_underflow", 32'(underflow), 32'd0);
        repeat (3) tick();
        check_val("hold_rgb", {20'd0, red, green, blue}, 32'h00F);

        // Read event on an empty FIFO.
        read_px(1'b1);
        check_val("uf_rgb", {20'd0, red, green, blue}, 32'h000);
        check_val("uf_flag", 32'(underflow), 32'd1);
        repeat (4) tick();
        check_val("uf_sticky", 32'(underflow), 32'd1);
        sync_pulse();
        check_val("uf_cleared", 32'(underflow), 32'd0);
        check_val("uf_sync_level", 32'(level), 32'd0);

        // frame_sync with level=100 and a concurrent write attempt.
        for (int i = 0; i < 100; i++) push_word(12'(i + 1));
        check_val("l100_level", 32'(level), 32'd100);
        frame_sync = 1'b1; wr_valid = 1'b1; wr_data = 12'hABC;
        #1;
        check_val("sync_wr_ready", 32'(wr_ready), 32'd0);
        tick();
        frame_sync = 1'b0; wr_valid = 1'b0;
        check_val("sync_level", 32'(level), 32'd0);
        push_word(12'h5A5);
        repeat (2) tick();
        read_px(1'b1);
        check_val("post_sync_rgb", {20'd0, red, green, blue}, 32'h5A5);
        check_val("post_sync_level", 32'(level), 32'd0);

        // A strobe outside the active area blanks without popping.
        push_word(12'h777);
        repeat (2) tick();
        read_px(1'b0);
        check_val("blank_rgb", {20'd0, red, green, blue}, 32'h000);
        check_val("blank_level", 32'(level), 32'd1);

        // Simultaneous push and pop keeps the level.
        wr_valid = 1'b1; wr_data = 12'h222;
        read_px(1'b1);
        wr_valid = 1'b0;
        check_val("pp_rgb", {20'd0, red, green, blue}, 32'h777);
        check_val("pp_level", 32'(level), 32'd1);
        repeat (2) tick();
        read_px(1'b1);
        check_val("pp_second", {20'd0, red, green, blue}, 32'h222);
        check_val("pp_underflow", 32'(underflow), 32'd0);

`ifdef FIFO_WATERMARK_EN
        sync_pulse();
        check_val("wm_after_sync", 32'(level_min), 32'd512);
        for (int i = 0; i < 50; i++) push_word(12'(i));
        repeat (2) tick();
        for (int r = 0; r < 20; r++) begin
            if (r % 4 == 3) begin
                wr_valid = 1'b1;
                wr_data  = 12'(r);
            end
            read_px(1'b1);
            wr_valid = 1'b0;
        end
        check_val("wm_min", 32'(level_min), 32'd35);
        sync_pulse();
        check_val("wm_reset", 32'(level_min), 32'd512);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
